pong_round_controller: RTL and testbench

Sequencer for one Pong round/match on a single board. Sits between the per-frame `update_screen` tick and the ball/paddle datapath in `gameStateModule`, gating when the paddle and ball advance. Owns the serve handshake (local arcade button or remote serve from the other board), the serve delay, scoring on miss events, and the match-over condition.

---
 rtl/pong_pkg.sv | 18 +
 rtl/pong_round_controller_frame_down_counter.sv | 39 +++
 rtl/pong_round_controller.sv | 202 ++++++++++++++++++++
 tb/tb_pong_round_controller.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong round controller and its frame counters.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SERVE_WAIT  = 3'd1,
    ST_SERVE_DELAY = 3'd2,
    ST_PLAY        = 3'd3,
    ST_POINT       = 3'd4,
    ST_OVER        = 3'd5
  } state_e;

  localparam int SCORE_W_DEF = 4;
  localparam int CNT_W       = 16;

  typedef logic [SCORE_W_DEF-1:0] score_t;

endpackage

// File: rtl/pong_round_controller_frame_down_counter.sv
// Loadable frame down-counter: decrements on each frame tick, flags zero and the expiring tick.
module frame_down_counter
  import pong_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero,
  output logic         expire
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero   = (count_q == '0);
  // expire marks the tick that takes the count from 1 to 0, so the caller moves on that edge
  assign expire = !load && tick && (count_q == W'(1));

endmodule

// File: rtl/pong_round_controller.sv
// Pong round/match sequencer: serve handshake, serve delay, scoring and match-over.
// Optional auto-serve timeout in SERVE_WAIT is enabled by defining PONG_SERVE_TIMEOUT_EN.
//
// state        | meaning
// IDLE         | power-up, waiting for first button press
// SERVE_WAIT   | ball held at centre, waiting for the server
// SERVE_DELAY  | serve accepted, counting frames before launch
// PLAY         | ball in motion
// POINT        | one cycle, credit the scorer
// OVER         | match finished, scores frozen
module pong_round_controller
  import pong_pkg::*;
#(
  parameter int SCORE_W              = 4,
  parameter int WIN_SCORE            = 7,
  parameter int SERVE_DELAY_FRAMES   = 60,
  parameter int SERVE_TIMEOUT_FRAMES = 300
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               update_screen,
  input  logic               arcade_button_pressed,
  input  logic               remote_serve,
  input  logic               is_left_player,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               paddle_step,
  output logic               ball_step,
  output logic               ball_reset,
  output logic               serve_left,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               game_over,
  output logic               winner_left,
  output logic [2:0]         state_o
);

  if (WIN_SCORE < 1 || WIN_SCORE > (2**SCORE_W) - 1) begin : g_bad_win_score
    $error("WIN_SCORE out of range for SCORE_W");
  end
  if (SERVE_DELAY_FRAMES < 1) begin : g_bad_serve_delay
    $error("SERVE_DELAY_FRAMES must be at least 1");
  end

  localparam logic [SCORE_W-1:0] WIN_Q = SCORE_W'(WIN_SCORE);

  state_e             state_q, state_d;
  logic               btn_q;
  logic               serve_left_q, serve_left_d;
  logic               credit_left_q, credit_left_d;
  logic               winner_left_q, winner_left_d;
  logic               paddle_step_q, paddle_step_d;
  logic               ball_step_q, ball_step_d;
  logic               ball_reset_q, ball_reset_d;
  logic               game_over_q, game_over_d;
  logic [SCORE_W-1:0] score_left_q, score_left_d;
  logic [SCORE_W-1:0] score_right_q, score_right_d;
  logic [SCORE_W-1:0] score_inc;

  logic btn_evt, local_serve, remote_ok;
  logic delay_load, delay_zero, delay_expire;
  logic timeout_fire;

  assign btn_evt     = arcade_button_pressed && !btn_q;
  assign local_serve = btn_evt && (serve_left_q == is_left_player);
  assign remote_ok   = remote_serve && (serve_left_q != is_left_player);
  assign score_inc   = credit_left_q ? score_left_q : score_right_q;

  frame_down_counter #(.W(CNT_W)) u_delay_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (delay_load),
    .load_val (CNT_W'(SERVE_DELAY_FRAMES)),
    .tick     (update_screen),
    .zero     (delay_zero),
    .expire   (delay_expire)
  );

`ifdef PONG_SERVE_TIMEOUT_EN
  logic timeout_load, timeout_zero, timeout_expire;
  assign timeout_load = (state_d == ST_SERVE_WAIT) && (state_q != ST_SERVE_WAIT);
  assign timeout_fire = timeout_expire || timeout_zero;

  frame_down_counter #(.W(CNT_W)) u_timeout_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (timeout_load),
    .load_val (CNT_W'(SERVE_TIMEOUT_FRAMES)),
    .tick     (update_screen),
    .zero     (timeout_zero),
    .expire   (timeout_expire)
  );
`else
  assign timeout_fire = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    serve_left_d  = serve_left_q;
    credit_left_d = credit_left_q;
    winner_left_d = winner_left_q;
    score_left_d  = score_left_q;
    score_right_d = score_right_q;
    delay_load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        score_left_d  = '0;
        score_right_d = '0;
        if (btn_evt) state_d = ST_SERVE_WAIT;
      end
      ST_SERVE_WAIT: begin
        if (local_serve || remote_ok || timeout_fire) begin
          state_d    = ST_SERVE_DELAY;
          delay_load = 1'b1;
        end
      end
      ST_SERVE_DELAY: begin
        if (delay_expire || delay_zero) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (miss_left && miss_right) begin
          state_d = ST_SERVE_WAIT;
        end else if (miss_left) begin
          credit_left_d = 1'b0;
          state_d       = ST_POINT;
        end else if (miss_right) begin
          credit_left_d = 1'b1;
          state_d       = ST_POINT;
        end
      end
      ST_POINT: begin
        // saturating increment keeps the score from wrapping
        if (score_inc != '1) begin
          if (credit_left_q) score_left_d  = score_left_q + 1'b1;
          else               score_right_d = score_right_q + 1'b1;
        end
        if ((credit_left_q ? score_left_d : score_right_d) == WIN_Q) begin
          state_d       = ST_OVER;
          winner_left_d = credit_left_q;
        end else begin
          state_d      = ST_SERVE_WAIT;
          serve_left_d = !credit_left_q;
        end
      end
      ST_OVER: begin
        if (btn_evt) begin
          state_d       = ST_SERVE_WAIT;
          score_left_d  = '0;
          score_right_d = '0;
          serve_left_d  = 1'b1;
          winner_left_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    paddle_step_d = update_screen && (state_d != ST_OVER);
    ball_step_d   = update_screen && (state_q == ST_PLAY) && (state_d == ST_PLAY);
    ball_reset_d  = (state_d != ST_PLAY);
    game_over_d   = (state_d == ST_OVER);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      btn_q         <= 1'b0;
      serve_left_q  <= 1'b1;
      credit_left_q <= 1'b0;
      winner_left_q <= 1'b0;
      paddle_step_q <= 1'b0;
      ball_step_q   <= 1'b0;
      ball_reset_q  <= 1'b1;
      game_over_q   <= 1'b0;
      score_left_q  <= '0;
      score_right_q <= '0;
    end else begin
      state_q       <= state_d;
      btn_q         <= arcade_button_pressed;
      serve_left_q  <= serve_left_d;
      credit_left_q <= credit_left_d;
      winner_left_q <= winner_left_d;
      paddle_step_q <= paddle_step_d;
      ball_step_q   <= ball_step_d;
      ball_reset_q  <= ball_reset_d;
      game_over_q   <= game_over_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
    end
  end

  assign paddle_step = paddle_step_q;
  assign ball_step   = ball_step_q;
  assign ball_reset  = ball_reset_q;
  assign serve_left  = serve_left_q;
  assign score_left  = score_left_q;
  assign score_right = score_right_q;
  assign game_over   = game_over_q;
  assign winner_left = winner_left_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pong_round_controller.sv
// Self-checking bench for pong_round_controller with a match-level reference model.
module tb_pong_round_controller;

  localparam int DLY = 3;
  localparam int WIN = 2;
  localparam int TMO = 5;
  localparam logic [2:0] S_IDLE = 3'd0, S_SW = 3'd1, S_SD = 3'd2,
                         S_PLAY = 3'd3, S_POINT = 3'd4, S_OVER = 3'd5;

  logic clock = 1'b0, reset_n = 1'b0;
  logic update_screen = 1'b0, arcade_button_pressed = 1'b0, remote_serve = 1'b0;
  logic is_left_player = 1'b1, miss_left = 1'b0, miss_right = 1'b0;
  logic paddle_step, ball_step, ball_reset, serve_left, game_over, winner_left;
  logic [3:0] score_left, score_right;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  // match-level model: scores, who serves next, and the result
  int m_sl, m_sr;
  bit m_serve_left, m_over, m_winner;

  pong_round_controller #(
    .SCORE_W(4), .WIN_SCORE(WIN), .SERVE_DELAY_FRAMES(DLY), .SERVE_TIMEOUT_FRAMES(TMO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .update_screen(update_screen),
    .arcade_button_pressed(arcade_button_pressed), .remote_serve(remote_serve),
    .is_left_player(is_left_player), .miss_left(miss_left), .miss_right(miss_right),
    .paddle_step(paddle_step), .ball_step(ball_step), .ball_reset(ball_reset),
    .serve_left(serve_left), .score_left(score_left), .score_right(score_right),
    .game_over(game_over), .winner_left(winner_left), .state_o(state_o)
  );

  always #5 clock = ~clock;

  function automatic void model_reset();
    m_sl = 0; m_sr = 0; m_serve_left = 1'b1; m_over = 1'b0; m_winner = 1'b0;
  endfunction

  function automatic void apply_miss(bit l, bit r);
    if (l && r) return;
    if (r) begin
      m_sl++;
      if (m_sl == WIN) begin m_over = 1'b1; m_winner = 1'b1; end
      else m_serve_left = 1'b0;
    end else if (l) begin
      m_sr++;
      if (m_sr == WIN) begin m_over = 1'b1; m_winner = 1'b0; end
      else m_serve_left = 1'b1;
    end
  endfunction

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic press();
    arcade_button_pressed = 1'b0; step();
    arcade_button_pressed = 1'b1; step();
  endtask

  task automatic pulse_miss(bit l, bit r);
    miss_left = l; miss_right = r; step();
    miss_left = 1'b0; miss_right = 1'b0;
  endtask

  task automatic do_serve();
    if (m_serve_left == is_left_player) press();
    else begin remote_serve = 1'b1; step(); remote_serve = 1'b0; end
  endtask

  task automatic wait_delay();
    update_screen = 1'b1;
    repeat (DLY) step();
  endtask

  task automatic test_reset();
    update_screen = 1'b1;
    reset_n = 1'b0;
    step();
    n_checks++;
    if ({state_o, paddle_step, ball_step, ball_reset, serve_left, score_left, score_right, game_over, winner_left}
        !== {S_IDLE, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got st=%0d ps=%b bs=%b br=%b sl=%b scL=%0d scR=%0d go=%b wl=%b, expected st=0 ps=0 bs=0 br=1 sl=1 scores 0 go=0 wl=0",
               state_o, paddle_step, ball_step, ball_reset, serve_left, score_left, score_right, game_over, winner_left);
    end
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if ({state_o, ball_step, paddle_step, ball_reset} !== {S_IDLE, 1'b0, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL idle_hold cycle %0d: got st=%0d bs=%b ps=%b br=%b, expected st=0 bs=0 ps=1 br=1",
                 i, state_o, ball_step, paddle_step, ball_reset);
      end
    end
  endtask

  task automatic test_serve_local();
    bit u;
    is_left_player = 1'b1;
    press();
    n_checks++;
    if ({state_o, ball_reset} !== {S_SW, 1'b1}) begin
      n_fail++; $display("FAIL idle_to_serve_wait: got st=%0d br=%b, expected st=1 br=1", state_o, ball_reset);
    end
    press();
    n_checks++;
    if (state_o !== S_SD) begin
      n_fail++; $display("FAIL local_serve: got st=%0d, expected 2", state_o);
    end
    repeat (DLY - 1) step();
    n_checks++;
    if (state_o !== S_SD) begin
      n_fail++; $display("FAIL delay_not_done: got st=%0d, expected 2", state_o);
    end
    step();
    n_checks++;
    if ({state_o, ball_reset, ball_step} !== {S_PLAY, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL enter_play: got st=%0d br=%b bs=%b, expected st=3 br=0 bs=0", state_o, ball_reset, ball_step);
    end
    for (int i = 0; i < 16; i++) begin
      u = 1'($urandom_range(0, 1));
      update_screen = u;
      step();
      n_checks++;
      if ({ball_step, paddle_step} !== {u, u}) begin
        n_fail++; $display("FAIL play_steps cycle %0d: got bs=%b ps=%b, expected both %b", i, ball_step, paddle_step, u);
      end
    end
    update_screen = 1'b1;
  endtask

  task automatic test_point_remote();
    int ticks, guard;
    bit u;
    pulse_miss(1'b0, 1'b1);
    apply_miss(1'b0, 1'b1);
    n_checks++;
    if (state_o !== S_POINT) begin
      n_fail++; $display("FAIL point_state: got st=%0d, expected 4", state_o);
    end
    step();
    n_checks++;
    if ({state_o, score_left, score_right, serve_left} !== {S_SW, 4'(m_sl), 4'(m_sr), m_serve_left}) begin
      n_fail++; $display("FAIL score_left_point: got st=%0d scL=%0d scR=%0d sl=%b, expected st=1 scL=%0d scR=%0d sl=%b",
                         state_o, score_left, score_right, serve_left, m_sl, m_sr, m_serve_left);
    end
    press();
    arcade_button_pressed = 1'b0;
    n_checks++;
    if (state_o !== S_SW) begin
      n_fail++; $display("FAIL wrong_side_button: got st=%0d, expected 1", state_o);
    end
    remote_serve = 1'b1; step(); remote_serve = 1'b0;
    n_checks++;
    if (state_o !== S_SD) begin
      n_fail++; $display("FAIL remote_serve: got st=%0d, expected 2", state_o);
    end
    ticks = 0; guard = 0;
    while (ticks < DLY && guard < 200) begin
      u = 1'($urandom_range(0, 1));
      update_screen = u;
      step();
      guard++;
      if (u) ticks++;
      n_checks++;
      if (state_o !== ((ticks == DLY) ? S_PLAY : S_SD)) begin
        n_fail++; $display("FAIL delay_ticks after %0d ticks: got st=%0d", ticks, state_o);
      end
    end
    n_checks++;
    if (ticks != DLY) begin
      n_fail++; $display("FAIL delay_budget: got %0d ticks, expected %0d", ticks, DLY);
    end
    update_screen = 1'b1;
  endtask

  task automatic test_double_miss();
    pulse_miss(1'b1, 1'b1);
    apply_miss(1'b1, 1'b1);
    n_checks++;
    if ({state_o, score_left, score_right, serve_left} !== {S_SW, 4'(m_sl), 4'(m_sr), m_serve_left}) begin
      n_fail++; $display("FAIL double_miss: got st=%0d scL=%0d scR=%0d sl=%b, expected st=1 scL=%0d scR=%0d sl=%b",
                         state_o, score_left, score_right, serve_left, m_sl, m_sr, m_serve_left);
    end
    do_serve();
    wait_delay();
    n_checks++;
    if (state_o !== S_PLAY) begin
      n_fail++; $display("FAIL replay_after_double: got st=%0d, expected 3", state_o);
    end
  endtask

  task automatic test_match_over();
    update_screen = 1'b1;
    pulse_miss(1'b0, 1'b1);
    apply_miss(1'b0, 1'b1);
    step();
    n_checks++;
    if ({state_o, game_over, winner_left, score_left, score_right, paddle_step, ball_reset}
        !== {S_OVER, m_over, m_winner, 4'(m_sl), 4'(m_sr), 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL match_over: got st=%0d go=%b wl=%b scL=%0d scR=%0d ps=%b br=%b, expected st=5 go=1 wl=1 scL=%0d scR=%0d ps=0 br=1",
                         state_o, game_over, winner_left, score_left, score_right, paddle_step, ball_reset, m_sl, m_sr);
    end
    pulse_miss(1'b1, 1'b0);
    step();
    n_checks++;
    if ({state_o, score_left, score_right} !== {S_OVER, 4'(m_sl), 4'(m_sr)}) begin
      n_fail++; $display("FAIL over_ignores_miss: got st=%0d scL=%0d scR=%0d, expected st=5 scL=%0d scR=%0d",
                         state_o, score_left, score_right, m_sl, m_sr);
    end
    press();
    model_reset();
    n_checks++;
    if ({state_o, score_left, score_right, serve_left, game_over} !== {S_SW, 4'd0, 4'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL over_restart: got st=%0d scL=%0d scR=%0d sl=%b go=%b, expected st=1 scores 0 sl=1 go=0",
                         state_o, score_left, score_right, serve_left, game_over);
    end
  endtask

  task automatic test_timeout();
`ifdef PONG_SERVE_TIMEOUT_EN
    int ticks, guard;
    bit u;
    ticks = 0; guard = 0;
    while (ticks < TMO && guard < 300) begin
      u = 1'($urandom_range(0, 1));
      update_screen = u;
      step();
      guard++;
      if (u) ticks++;
      n_checks++;
      if (state_o !== ((ticks == TMO) ? S_SD : S_SW)) begin
        n_fail++; $display("FAIL timeout_ticks after %0d ticks: got st=%0d", ticks, state_o);
      end
    end
    n_checks++;
    if (ticks != TMO) begin
      n_fail++; $display("FAIL timeout_budget: got %0d ticks, expected %0d", ticks, TMO);
    end
`else
    update_screen = 1'b1;
    repeat (40) step();
    n_checks++;
    if (state_o !== S_SW) begin
      n_fail++; $display("FAIL no_timeout_wait: got st=%0d, expected 1", state_o);
    end
    do_serve();
`endif
    wait_delay();
    n_checks++;
    if (state_o !== S_PLAY) begin
      n_fail++; $display("FAIL serve_after_wait: got st=%0d, expected 3", state_o);
    end
  endtask

  task automatic test_async_reset();
    pulse_miss(1'b0, 1'b1);
    apply_miss(1'b0, 1'b1);
    step();
    do_serve();
    wait_delay();
    n_checks++;
    if ({state_o, score_left} !== {S_PLAY, 4'(m_sl)}) begin
      n_fail++; $display("FAIL pre_reset_play: got st=%0d scL=%0d, expected st=3 scL=%0d", state_o, score_left, m_sl);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({state_o, score_left, score_right, serve_left, ball_reset, ball_step} !== {S_IDLE, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL async_reset: got st=%0d scL=%0d scR=%0d sl=%b br=%b bs=%b, expected st=0 scores 0 sl=1 br=1 bs=0",
                         state_o, score_left, score_right, serve_left, ball_reset, ball_step);
    end
    step();
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random_rallies();
    int o;
    bit l, r;
    arcade_button_pressed = 1'b0;
    press();
    for (int n = 0; n < 14; n++) begin
      is_left_player = 1'($urandom_range(0, 1));
      update_screen = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        if (m_serve_left == is_left_player) begin
          remote_serve = 1'b1; step(); remote_serve = 1'b0;
        end else begin
          press();
        end
        n_checks++;
        if (state_o !== S_SW) begin
          n_fail++; $display("FAIL rally%0d_ignored_serve: got st=%0d, expected 1", n, state_o);
        end
      end
      do_serve();
      n_checks++;
      if (state_o !== S_SD) begin
        n_fail++; $display("FAIL rally%0d_serve: got st=%0d, expected 2", n, state_o);
      end
      wait_delay();
      repeat ($urandom_range(0, 3)) begin
        update_screen = 1'($urandom_range(0, 1));
        step();
      end
      o = $urandom_range(0, 2);
      l = (o != 1);
      r = (o != 0);
      pulse_miss(l, r);
      apply_miss(l, r);
      step();
      n_checks++;
      if ({state_o, score_left, score_right, game_over, (m_over ? winner_left : serve_left)}
          !== {(m_over ? S_OVER : S_SW), 4'(m_sl), 4'(m_sr), m_over, (m_over ? m_winner : m_serve_left)}) begin
        n_fail++; $display("FAIL rally%0d_outcome l=%b r=%b: got st=%0d scL=%0d scR=%0d go=%b wl=%b sl=%b, expected scL=%0d scR=%0d over=%b winner=%b serve_left=%b",
                           n, l, r, state_o, score_left, score_right, game_over, winner_left, serve_left,
                           m_sl, m_sr, m_over, m_winner, m_serve_left);
      end
      if (m_over) begin
        press();
        model_reset();
        n_checks++;
        if ({state_o, score_left, score_right, serve_left} !== {S_SW, 4'd0, 4'd0, 1'b1}) begin
          n_fail++; $display("FAIL rally%0d_restart: got st=%0d scL=%0d scR=%0d sl=%b", n, state_o, score_left, score_right, serve_left);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve_local();
    test_point_remote();
    test_double_miss();
    test_match_over();
    test_timeout();
    test_async_reset();
    test_random_rallies();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
